// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor control path: opcodes, instruction
// fields, sequencer states and trap causes.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_ORI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'he;
  localparam logic [3:0] OP_BNE  = 4'hf;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_MSB  = 3;
  localparam int unsigned JMP_LSB  = 4;
  localparam int unsigned JMP_MSB  = 12;
  localparam int unsigned BOFF_LSB = 10;
  localparam int unsigned BOFF_MSB = 15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'b00,
    CauseIllegal = 2'b01,
    CauseImemTo  = 2'b10,
    CauseDmemTo  = 2'b11
  } trap_cause_e;

  typedef struct packed {
    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_jmp;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode classifier; exactly one class bit is set for any opcode.
module opclass_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output opclass_t   cls_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: cls_o.is_r   = 1'b1;
      OP_ADDI, OP_ORI:                       cls_o.is_i   = 1'b1;
      OP_LD:                                 cls_o.is_ld  = 1'b1;
      OP_ST:                                 cls_o.is_st  = 1'b1;
      OP_BEQ, OP_BNE:                        cls_o.is_br  = 1'b1;
      OP_JMP:                                cls_o.is_jmp = 1'b1;
      default:                               cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM. Owns the PC and instruction
// register and traps on illegal opcodes or memory handshake timeouts.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  input  logic              alu_zero,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              alu_en,
  output logic              reg_we,
  output logic              mem_to_reg,
  output logic              trap,
  output logic [1:0]        trap_cause
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [7:0]        wait_q, wait_d;
  logic              trap_q, trap_d;
  trap_cause_e       cause_q, cause_d;

  opclass_t          cls;
  logic [ADDR_W-1:0] pc_inc, pc_br, pc_jmp, boff;
  logic              taken, wait_limit;

  opclass_decode u_opclass_decode (
    .opcode_i (instr_q[OPC_MSB:OPC_LSB]),
    .cls_o    (cls)
  );

  assign pc_inc     = pc_q + ADDR_W'(1);
  // Signed cast sign-extends the 6-bit branch offset to the PC width.
  assign boff       = ADDR_W'($signed(instr_q[BOFF_MSB:BOFF_LSB]));
  assign pc_br      = pc_inc + boff;
  assign pc_jmp     = ADDR_W'(instr_q[JMP_MSB:JMP_LSB]);
  assign taken      = (instr_q[OPC_MSB:OPC_LSB] == OP_BNE) ? ~alu_zero : alu_zero;
  assign wait_limit = (wait_q == TimeoutCnt);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    trap_d  = trap_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          wait_d  = '0;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end else if (wait_limit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = CauseImemTo;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        if (cls.illegal) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = CauseIllegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (cls.is_jmp || cls.is_br) begin
          if (cls.is_jmp) pc_d = pc_jmp;
          else            pc_d = taken ? pc_br : pc_inc;
          state_d = run ? StFetch : StIdle;
          wait_d  = '0;
        end else if (cls.is_ld || cls.is_st) begin
          state_d = StMem;
          wait_d  = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ack) begin
          if (cls.is_st) begin
            pc_d    = pc_inc;
            state_d = run ? StFetch : StIdle;
            wait_d  = '0;
          end else begin
            state_d = StWb;
          end
        end else if (wait_limit) begin
          state_d = StTrap;
          trap_d  = 1'b1;
          cause_d = CauseDmemTo;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        pc_d    = pc_inc;
        state_d = run ? StFetch : StIdle;
        wait_d  = '0;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes depend only on state and the latched instruction.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      StFetch: imem_req = 1'b1;
      StExec:  alu_en = cls.is_r | cls.is_i | cls.is_ld | cls.is_st | cls.is_br;
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = cls.is_st;
      end
      StWb: begin
        reg_we     = 1'b1;
        mem_to_reg = cls.is_ld;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign instr      = instr_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule
